// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_run_ctrl: run/step/halt sequencer for a CPU core with a register-write |
// | trace FIFO.                                      Revision: 1.0             |
// +----------------------------------------------------------------------------+
module cpu_run_ctrl #(
  parameter int          PC_W        = 64,
  parameter int          MAX_CYCLES  = 15,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] HALT_INSTR  = 32'hD440_0000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             STEP_MODE,
  input  logic             STEP,
  input  logic [PC_W-1:0]  PC,
  input  logic [31:0]      INSTRUCTION,
  input  logic             REGWRITE,
  input  logic [4:0]       WRITE_REG,
  input  logic [63:0]      WRITE_DATA,
  output logic             CPU_EN,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] CYCLE_COUNT,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [PC_W-1:0]  HALT_PC,
  output logic             TRACE_VALID,
  input  logic             TRACE_READY,
  output logic [4:0]       TRACE_REG,
  output logic [63:0]      TRACE_DATA,
  output logic             TRACE_OVERFLOW
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int               AW      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(TRACE_DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic             ovf_q, ovf_d;
  logic [AW:0]      fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [68:0]      mem_q [TRACE_DEPTH];

  logic             cpu_en;
  logic [CNT_W-1:0] cnt_inc;
  logic             halt_hit;
  logic             timeout_hit;
  logic             ovf_clr;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [68:0]      head;

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      S_RUN:   cpu_en = 1'b1;
      S_PAUSE: cpu_en = STEP;
      default: cpu_en = 1'b0;
    endcase
  end

  assign cnt_inc     = cnt_q + 1'b1;
  assign halt_hit    = cpu_en && (INSTRUCTION == HALT_INSTR);
  assign timeout_hit = cpu_en && !halt_hit && (cnt_inc == MAX_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    halt_pc_d = halt_pc_q;
    ovf_clr   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (START) begin
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          ovf_clr   = 1'b1;
          state_d   = STEP_MODE ? S_PAUSE : S_RUN;
        end
      end
      S_RUN:   if (STEP_MODE)  state_d = S_PAUSE;
      S_PAUSE: if (!STEP_MODE) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    // The cycle that halts is itself an enabled cycle and is counted.
    if (cpu_en && (cnt_q < MAX_C)) cnt_d = cnt_inc;
    if (halt_hit || timeout_hit) begin
      state_d   = S_HALT;
      done_d    = halt_hit;
      timeout_d = timeout_hit;
      halt_pc_d = PC;
    end
  end

  assign push_req   = cpu_en && REGWRITE && (WRITE_REG != 5'd31);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == DEPTH_C);
  assign pop        = !fifo_empty && TRACE_READY;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    ovf_d = ovf_clr ? 1'b0 : (ovf_q | (push_req && !push));
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      halt_pc_q  <= '0;
      ovf_q      <= 1'b0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      halt_pc_q  <= halt_pc_d;
      ovf_q      <= ovf_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= {WRITE_REG, WRITE_DATA};
  end

  assign head           = mem_q[rd_ptr_q];
  assign CPU_EN         = cpu_en;
  assign STATE          = state_q;
  assign CYCLE_COUNT    = cnt_q;
  assign DONE           = done_q;
  assign TIMEOUT        = timeout_q;
  assign HALT_PC        = halt_pc_q;
  assign TRACE_VALID    = !fifo_empty;
  assign TRACE_REG      = fifo_empty ? 5'd0  : head[68:64];
  assign TRACE_DATA     = fifo_empty ? 64'd0 : head[63:0];
  assign TRACE_OVERFLOW = ovf_q;

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 64: width of the CPU program counter.
REQ-002 SHALL have parameter MAX_CYCLES, default 15: enabled-cycle budget before timeout; legal range >=1.
REQ-003 SHALL have parameter CNT_W, default 16: cycle counter width; MAX_CYCLES < 2^CNT_W.
REQ-004 SHALL have parameter HALT_INSTR, default 32'hD440_0000: 32-bit encoding treated as halt.
REQ-005 SHALL have parameter TRACE_DEPTH, default 8: trace FIFO entries; power of two, >=2.
REQ-006 SHALL have port CLOCK  in  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports START  in  1  (begin or restart run) and STEP_MODE  in  1  (1 = single-step).
REQ-009 SHALL have port STEP  in  1  advances one CPU cycle while in PAUSE.
REQ-010 SHALL have ports PC  in  PC_W  (CPU program counter) and INSTRUCTION  in  32  (current instruction).
REQ-011 SHALL have ports REGWRITE  in  1, WRITE_REG  in  5, WRITE_DATA  in  64: the CPU register-write bus.
REQ-012 SHALL have port CPU_EN  out  1  CPU clock enable.
REQ-013 SHALL have ports STATE  out  2, CYCLE_COUNT  out  CNT_W, DONE  out  1, TIMEOUT  out  1, HALT_PC  out  PC_W.
REQ-014 SHALL have ports TRACE_VALID  out  1, TRACE_READY  in  1, TRACE_REG  out  5, TRACE_DATA  out  64, TRACE_OVERFLOW  out  1.

Function
REQ-015 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, HALT=3, exposed on STATE.
REQ-016 SHALL drive CPU_EN combinationally: 1 in RUN; equal to STEP in PAUSE; 0 in IDLE and HALT.
REQ-017 SHALL treat a cycle as "enabled" when CPU_EN=1; CYCLE_COUNT increments by 1 per enabled cycle, saturating at MAX_CYCLES.
REQ-018 SHALL, in IDLE or HALT, on START=1, clear CYCLE_COUNT, DONE, TIMEOUT and TRACE_OVERFLOW, and enter PAUSE if STEP_MODE=1, else RUN.
REQ-019 SHALL, in RUN, move to PAUSE when STEP_MODE=1 (no enabled-cycle loss: that cycle still enabled).
REQ-020 SHALL, in PAUSE, move to RUN when STEP_MODE=0.
REQ-021 SHALL, on an enabled cycle with INSTRUCTION==HALT_INSTR, enter HALT next edge, set DONE=1, capture PC into HALT_PC.
REQ-022 SHALL, on an enabled cycle where CYCLE_COUNT+1 == MAX_CYCLES and no halt, enter HALT, set TIMEOUT=1, capture PC into HALT_PC.
REQ-023 SHALL give halt priority over timeout in the same cycle: DONE=1, TIMEOUT=0.
REQ-024 SHALL ignore START while in RUN or PAUSE.
REQ-025 SHALL push {WRITE_REG, WRITE_DATA} into the trace FIFO on an enabled cycle with REGWRITE=1 and WRITE_REG!=31.
REQ-026 SHALL present FIFO head on TRACE_REG/TRACE_DATA with TRACE_VALID=1 when non-empty; pop on TRACE_VALID&&TRACE_READY.
REQ-027 SHALL, when full, drop a push and set sticky TRACE_OVERFLOW, unless a pop occurs the same cycle, in which case the push is accepted.
REQ-028 SHALL, when empty, ignore TRACE_READY; simultaneous push and pop on empty leaves one entry (the pushed one).
REQ-029 SHALL wrap FIFO pointers modulo TRACE_DEPTH; FIFO contents persist across START (only overflow flag cleared).

Reset
REQ-030 SHALL, while RESET_N=0, force STATE=IDLE, CPU_EN=0, CYCLE_COUNT=0, DONE=0, TIMEOUT=0, HALT_PC=0, FIFO empty (TRACE_VALID=0), TRACE_OVERFLOW=0, TRACE_REG=0, TRACE_DATA=0.
REQ-031 SHALL apply reset asynchronously, including mid-run; first edge after release sees IDLE.

Verification
REQ-032 Run to timeout: START, STEP_MODE=0, INSTRUCTION never halt -> CPU_EN high exactly 15 cycles, TIMEOUT=1, DONE=0, CYCLE_COUNT=15, STATE=3.
REQ-033 Halt: INSTRUCTION=32'hD440_0000 on 4th enabled cycle with PC=64'h0C -> DONE=1, HALT_PC=64'h0C, CYCLE_COUNT=4; halt on 15th cycle -> DONE=1, TIMEOUT=0.
REQ-034 Single-step: STEP_MODE=1, START, three 1-cycle STEP pulses spaced 5 cycles -> CPU_EN high exactly 3 cycles, CYCLE_COUNT=3, STATE=2.
REQ-035 Trace: 10 writes (X1..X10, data=reg*0x11) with TRACE_READY=0, then drain -> 8 entries X1..X8 in order, TRACE_OVERFLOW=1; write to X31 never traced.
REQ-036 Full FIFO with simultaneous push/pop -> push accepted, no overflow, count stays 8.
REQ-037 RESET_N low for 1 ns mid-RUN at CYCLE_COUNT=7 -> all outputs to REQ-030 values immediately; START afterwards begins at count 0.
